// File: rtl/banked_data_ram_pkg.sv
// ============================================================================
// Module  : banked_data_ram_pkg
// Brief   : Shared constants, clear-FSM encoding and clog2 helper for the
//           banked data RAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package banked_data_ram_pkg;

  localparam int LANE_W           = 8;
  localparam int MAX_READ_LATENCY = 3;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_ram.sv
// ============================================================================
// Module  : byte_lane_ram
// Brief   : One 8-bit lane of the data array; synchronous write and read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_lane_ram
  import banked_data_ram_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [LANE_W-1:0] wdata,
  output logic [LANE_W-1:0] rdata
);

  logic [LANE_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [LANE_W-1:0] r_rdata;

  // Read returns the pre-write contents on a same-address write cycle.
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
    r_rdata <= r_mem[addr];
  end

  assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/banked_data_ram.sv
// ============================================================================
// Module  : banked_data_ram
// Brief   : Byte-lane data memory with valid/ready requests, pipelined read,
//           out-of-range error reporting and optional post-reset zero sweep.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module banked_data_ram
  import banked_data_ram_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 1,
  parameter int CLR_ON_RESET = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [31:0]              req_addr,
  input  logic [DATA_W/LANE_W-1:0] req_sel,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err
);

  localparam int c_bytes = DATA_W / LANE_W;
  localparam int c_off   = clog2_f(c_bytes);
  localparam int c_top   = c_off + ADDR_W;
  localparam clr_state_e c_st_rst = (CLR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  clr_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx, w_clr_idx_nxt;
  logic              w_clearing;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_st_rst;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_clearing    = 1'b0;
    req_ready     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_clearing    = 1'b1;
        w_clr_idx_nxt = r_clr_idx + 1'b1;
        if (&r_clr_idx) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        req_ready = 1'b1;
      end
    endcase
  end

  // Address decode: word index plus range check on the bits above it.
  logic [ADDR_W-1:0] w_req_idx;
  logic              w_req_oor;

  assign w_req_idx = req_addr[c_top-1:c_off];

  if (c_top < 32) begin : g_range
    assign w_req_oor = |req_addr[31:c_top];
  end else begin : g_no_range
    assign w_req_oor = 1'b0;
  end

  if (c_off > 0) begin : g_lane_bits
    logic w_unused_addr_bits;
    assign w_unused_addr_bits = ^req_addr[c_off-1:0];
  end

  logic              w_accept;
  logic              w_wr;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_accept   = req_valid & req_ready;
  assign w_wr       = w_accept & req_we & ~w_req_oor;
  assign w_ram_addr = w_clearing ? r_clr_idx : w_req_idx;

  for (genvar k = 0; k < c_bytes; k++) begin : g_lane
    logic w_lane_we;
    assign w_lane_we = w_clearing | (w_wr & req_sel[k]);

    byte_lane_ram #(
      .ADDR_W (ADDR_W)
    ) u_lane (
      .clk   (clk),
      .we    (w_lane_we),
      .addr  (w_ram_addr),
      .wdata (w_clearing ? {LANE_W{1'b0}} : req_wdata[k*LANE_W +: LANE_W]),
      .rdata (w_ram_rdata[k*LANE_W +: LANE_W])
    );
  end

  // Stage 1 tracks the array read; data is forced to 0 unless a good read.
  logic              r_s1_valid, r_s1_err, r_s1_rd;
  logic [DATA_W-1:0] w_s1_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_rd    <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_err   <= w_accept & w_req_oor;
      r_s1_rd    <= w_accept & ~req_we & ~w_req_oor;
    end
  end

  assign w_s1_rdata = r_s1_rd ? w_ram_rdata : '0;

  if (READ_LATENCY <= 1) begin : g_lat1
    assign rsp_valid = r_s1_valid;
    assign rsp_err   = r_s1_err;
    assign rsp_rdata = w_s1_rdata;
  end else begin : g_pipe
    localparam int c_n = READ_LATENCY - 1;
    logic              r_v [0:c_n-1];
    logic              r_e [0:c_n-1];
    logic [DATA_W-1:0] r_d [0:c_n-1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < c_n; i++) begin
          r_v[i] <= 1'b0;
          r_e[i] <= 1'b0;
          r_d[i] <= '0;
        end
      end else begin
        r_v[0] <= r_s1_valid;
        r_e[0] <= r_s1_err;
        r_d[0] <= w_s1_rdata;
        for (int i = 1; i < c_n; i++) begin
          r_v[i] <= r_v[i-1];
          r_e[i] <= r_e[i-1];
          r_d[i] <= r_d[i-1];
        end
      end
    end

    assign rsp_valid = r_v[c_n-1];
    assign rsp_err   = r_e[c_n-1];
    assign rsp_rdata = r_d[c_n-1];
  end

endmodule

`default_nettype wire

// File: tb/tb_banked_data_ram.sv
// ============================================================================
// Module  : tb_banked_data_ram
// Brief   : Self-checking bench: table vectors, random traffic against a
//           word-array model, and reset/clear corner sequences.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_banked_data_ram;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int LAT    = 3;
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  banked_data_ram #(
    .DATA_W       (DATA_W),
    .ADDR_W       (ADDR_W),
    .READ_LATENCY (LAT),
    .CLR_ON_RESET (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_sel   (req_sel),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] model [0:DEPTH-1];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response scoreboard: every response must match the oldest outstanding
  // expectation, in order, exactly on its due cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL spurious_rsp: rsp_valid=1 with nothing outstanding at cycle %0d", cyc);
        end else begin
          mon_e = q.pop_front();
          if (rsp_rdata !== mon_e.rdata || rsp_err !== mon_e.err || cyc != mon_e.due) begin
            n_err++;
            $display("FAIL rsp: got rdata=0x%08h err=%0b cycle=%0d, expected rdata=0x%08h err=%0b cycle=%0d",
                     rsp_rdata, rsp_err, cyc, mon_e.rdata, mon_e.err, mon_e.due);
          end
        end
      end else if (q.size() != 0 && q[0].due <= cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL missing_rsp: rsp_valid=0 at cycle %0d, expected response due at %0d", cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model_apply(input logic we, input logic [31:0] addr,
                                      input logic [3:0] sel, input logic [31:0] wdata,
                                      output logic [31:0] rd, output logic err);
    int idx;
    err = (addr[31:6] != 26'd0);
    rd  = 32'd0;
    idx = int'(addr[5:2]);
    if (!err) begin
      if (we) begin
        for (int k = 0; k < 4; k++)
          if (sel[k]) model[idx][8*k +: 8] = wdata[8*k +: 8];
      end else begin
        rd = model[idx];
      end
    end
  endfunction

  function automatic void model_zero();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
  endfunction

  // Called at a negedge; returns at the following negedge.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                       input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    int   c;
    logic rdy;
    exp_t e;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_sel   = sel;
    req_wdata = wdata;
    c   = cyc;
    rdy = req_ready;
    @(posedge clk);
    if (rdy) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.due   = c + LAT;
      q.push_back(e);
    end else begin
      n_vec++;
      n_err++;
      $display("FAIL not_ready: req_ready=0 when 1 was expected at cycle %0d", c);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic issue_model(input logic we, input logic [31:0] addr,
                             input logic [3:0] sel, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        err;
    model_apply(we, addr, sel, wdata, rd, err);
    issue(we, addr, sel, wdata, rd, err);
  endtask

  task automatic count_clear(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(n), 32'(DEPTH));
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < DEPTH; i++) issue(1'b0, 32'(i * 4), 4'h0, 32'h0, 32'h0, 1'b0);
  endtask

  vec_t tbl [0:13];

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b1, 32'h0000_0010, 4'h1, 32'h0000_00AA, 32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0000_0000, 32'hDEAD_BEAA, 1'b0};
    tbl[3]  = '{1'b1, 32'h0000_0040, 4'hF, 32'h1234_5678, 32'h0000_0000, 1'b1};
    tbl[4]  = '{1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[5]  = '{1'b0, 32'h0000_0040, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
    tbl[6]  = '{1'b1, 32'h0000_003C, 4'hF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
    tbl[7]  = '{1'b0, 32'h0000_003C, 4'h0, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    tbl[8]  = '{1'b1, 32'h0000_0004, 4'h0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    tbl[9]  = '{1'b0, 32'h0000_0004, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    tbl[10] = '{1'b1, 32'h0000_0008, 4'hA, 32'h1122_3344, 32'h0000_0000, 1'b0};
    tbl[11] = '{1'b0, 32'h0000_0008, 4'h0, 32'h0000_0000, 32'h1100_3300, 1'b0};
    tbl[12] = '{1'b0, 32'h0000_0013, 4'h0, 32'h0000_0000, 32'hDEAD_BEAA, 1'b0};
    tbl[13] = '{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b1};

    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_sel = '0; req_wdata = '0;
    model_zero();

    @(negedge clk);
    #1;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err",   32'(rsp_err), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    count_clear("clear_len_initial");
    read_all_zero();

    // Table vectors, back to back
    for (int i = 0; i < 14; i++) begin
      logic [31:0] rd_unused;
      logic        err_unused;
      model_apply(tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].wdata, rd_unused, err_unused);
      issue(tbl[i].we, tbl[i].addr, tbl[i].sel, tbl[i].wdata, tbl[i].exp_rdata, tbl[i].exp_err);
    end

    // Random traffic against the word-array model
    for (int n = 0; n < 300; n++) begin
      logic [31:0] addr;
      logic [31:0] hi;
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) begin
        hi = $urandom_range(1, (1 << 26) - 1);
        addr[31:6] = hi[25:0];
      end
      issue_model(1'($urandom_range(0, 1)), addr, 4'($urandom_range(0, 15)), $urandom);
    end
    repeat (LAT + 2) @(negedge clk);
    chk("drain_random", 32'(q.size()), 32'd0);

    // Reset with two reads in flight
    issue_model(1'b0, 32'h0000_0010, 4'h0, 32'h0);
    issue_model(1'b0, 32'h0000_003C, 4'h0, 32'h0);
    #2 rst = 1'b1;
    q.delete();
    #1;
    chk("inflight_rst_valid", 32'(rsp_valid), 32'd0);
    chk("inflight_rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    chk("inflight_rst_hold", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;

    // Partial clear interrupted at index 7 must restart from 0
    repeat (7) @(negedge clk);
    chk("midclear_ready", 32'(req_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("midclear_rst_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    count_clear("clear_len_restart");
    model_zero();
    read_all_zero();

    // Write then read next cycle after the re-clear
    issue_model(1'b1, 32'h0000_0024, 4'hF, 32'h0BAD_F00D);
    issue_model(1'b0, 32'h0000_0024, 4'h0, 32'h0);
    issue_model(1'b0, 32'h0000_0000, 4'h0, 32'h0);

    repeat (LAT + 2) @(negedge clk);
    chk("drain_final", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
